// File: rtl/data_mem_if.sv
// data_mem_if: address, write and read-data signals for one data_mem port
interface data_mem_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  wd;
    logic [WIDTH-1:0]  rd;
    modport master (output we, a, wd, input rd);
    modport slave  (input we, a, wd, output rd);
endinterface

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory with synchronous write, combinational read
// and an asynchronous active-low reset that clears every word.
module data_mem #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input logic       clk,
    input logic       rst_n,
    data_mem_if.slave bus
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range;
    assign in_range = int'(bus.a) < DEPTH;
    // Out-of-range addresses read as zero rather than aliasing onto real words
    assign bus.rd = in_range ? mem[bus.a] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.we && in_range) begin
            mem[bus.a] <= bus.wd;
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench driving a 64-word and a 48-word data_mem in lockstep.
module tb_data_mem;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        we = 0;
    logic [5:0]  a = '0;
    logic [31:0] wd = '0;
    logic [31:0] m64 [64];
    logic [31:0] m48 [64];
    logic [31:0] q [$];
    logic [31:0] e;
    int          errors = 0;
    int          checks = 0;

    data_mem_if #(.WIDTH(32), .ADDR_W(6)) b64 ();
    data_mem_if #(.WIDTH(32), .ADDR_W(6)) b48 ();
    assign b64.we = we;
    assign b64.a  = a;
    assign b64.wd = wd;
    assign b48.we = we;
    assign b48.a  = a;
    assign b48.wd = wd;

    data_mem #(.WIDTH(32), .ADDR_W(6), .DEPTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    data_mem #(.WIDTH(32), .ADDR_W(6), .DEPTH(48)) dut48 (.clk(clk), .rst_n(rst_n), .bus(b48));

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            m64[i] = '0;
            m48[i] = '0;
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1;
        a  = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 0;
        if (rst_n) begin
            m64[addr] = data;
            if (addr < 48) m48[addr] = data;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        clear_model();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a = 6'(i);
            q.push_back(m64[i]);
            q.push_back(m48[i]);
            #1;
            e = q.pop_front();
            checks++;
            if (b64.rd !== e) begin
                errors++;
                $display("FAIL reset_clear64 a=%0d rd=%h exp=%h", i, b64.rd, e);
            end
            e = q.pop_front();
            checks++;
            if (b48.rd !== e) begin
                errors++;
                $display("FAIL reset_clear48 a=%0d rd=%h exp=%h", i, b48.rd, e);
            end
        end
    endtask

    task automatic test_single_write();
        logic [5:0] addrs [3] = '{6'd5, 6'd4, 6'd6};
        do_write(6'd5, 32'h0000002B);
        foreach (addrs[k]) begin
            @(negedge clk);
            a = addrs[k];
            q.push_back(m64[addrs[k]]);
            #1;
            e = q.pop_front();
            checks++;
            if (b64.rd !== e) begin
                errors++;
                $display("FAIL single_write a=%0d rd=%h exp=%h", addrs[k], b64.rd, e);
            end
        end
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        we = 0;
        a  = 6'd7;
        wd = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        q.push_back(m64[7]);
        #1;
        e = q.pop_front();
        checks++;
        if (b64.rd !== e) begin
            errors++;
            $display("FAIL write_disabled a=7 rd=%h exp=%h", b64.rd, e);
        end
    endtask

    task automatic test_comb_read();
        logic [5:0] seq [4] = '{6'd0, 6'd63, 6'd0, 6'd63};
        do_write(6'd0, 32'h11111111);
        do_write(6'd63, 32'hFFFFFFFF);
        @(negedge clk);
        foreach (seq[k]) begin
            a = seq[k];
            q.push_back(m64[seq[k]]);
            q.push_back(m48[seq[k]]);
            #1;
            e = q.pop_front();
            checks++;
            if (b64.rd !== e) begin
                errors++;
                $display("FAIL comb_read64 a=%0d rd=%h exp=%h", seq[k], b64.rd, e);
            end
            e = q.pop_front();
            checks++;
            if (b48.rd !== e) begin
                errors++;
                $display("FAIL comb_read48 a=%0d rd=%h exp=%h", seq[k], b48.rd, e);
            end
        end
        @(negedge clk);
        we = 1;
        a  = 6'd0;
        wd = 32'h22222222;
        q.push_back(m64[0]);
        #1;
        e = q.pop_front();
        checks++;
        if (b64.rd !== e) begin
            errors++;
            $display("FAIL rdw_before rd=%h exp=%h", b64.rd, e);
        end
        @(posedge clk);
        #1;
        we = 0;
        m64[0] = 32'h22222222;
        m48[0] = 32'h22222222;
        q.push_back(m64[0]);
        e = q.pop_front();
        checks++;
        if (b64.rd !== e) begin
            errors++;
            $display("FAIL rdw_after rd=%h exp=%h", b64.rd, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        @(negedge clk);
        we = 1;
        a  = 6'd9;
        foreach (vals[k]) begin
            wd = vals[k];
            @(posedge clk);
            #1;
            m64[9] = vals[k];
            m48[9] = vals[k];
            q.push_back(m64[9]);
            e = q.pop_front();
            checks++;
            if (b64.rd !== e) begin
                errors++;
                $display("FAIL back_to_back edge=%0d rd=%h exp=%h", k, b64.rd, e);
            end
            @(negedge clk);
        end
        we = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) do_write(6'(i), 32'h1000_0000 + 32'(i) + 32'h1);
        @(negedge clk);
        rst_n = 0;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            a = 6'(i);
            q.push_back(m64[i]);
            #1;
            e = q.pop_front();
            checks++;
            if (b64.rd !== e) begin
                errors++;
                $display("FAIL async_reset a=%0d rd=%h exp=%h", i, b64.rd, e);
            end
        end
        do_write(6'd2, 32'h77777777);
        @(negedge clk);
        a = 6'd2;
        q.push_back(m64[2]);
        #1;
        e = q.pop_front();
        checks++;
        if (b64.rd !== e) begin
            errors++;
            $display("FAIL write_in_reset rd=%h exp=%h", b64.rd, e);
        end
        @(negedge clk);
        rst_n = 1;
        do_write(6'd3, 32'h0BADF00D);
        @(negedge clk);
        a = 6'd3;
        q.push_back(m64[3]);
        #1;
        e = q.pop_front();
        checks++;
        if (b64.rd !== e) begin
            errors++;
            $display("FAIL write_after_release rd=%h exp=%h", b64.rd, e);
        end
    endtask

    task automatic test_reduced_depth();
        do_write(6'd50, 32'hA5A5A5A5);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a = 6'(i);
            q.push_back(m48[i]);
            q.push_back(m64[i]);
            #1;
            e = q.pop_front();
            checks++;
            if (b48.rd !== e) begin
                errors++;
                $display("FAIL reduced_depth48 a=%0d rd=%h exp=%h", i, b48.rd, e);
            end
            e = q.pop_front();
            checks++;
            if (b64.rd !== e) begin
                errors++;
                $display("FAIL reduced_depth64 a=%0d rd=%h exp=%h", i, b64.rd, e);
            end
        end
    endtask

    initial begin
        clear_model();
        #12;
        rst_n = 1;
        test_reset();
        test_single_write();
        test_write_disabled();
        test_comb_read();
        test_back_to_back();
        test_async_reset();
        test_reduced_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
